// File: rtl/program_load_responder.sv
// Program-load write receiver: pairs AW/W beats in order and issues registered 512-bit RAM writes.
// Optional running checksum of written lanes is enabled by defining PROGRAM_LOAD_CHECKSUM_EN.
module program_load_responder #(
    parameter int ADDR_WIDTH    = 15,
    parameter int DATA_WIDTH    = 512,
    parameter int AW_FIFO_DEPTH = 4,
    parameter int IMAGE_BYTES   = 2048
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    program_load_en,
    input  logic                    program_load_aw_valid,
    output logic                    program_load_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   program_load_aw_payload_addr,
    input  logic                    program_load_w_valid,
    output logic                    program_load_w_ready,
    input  logic [DATA_WIDTH-1:0]   program_load_w_payload_data,
    input  logic [DATA_WIDTH/8-1:0] program_load_w_payload_strb,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-7:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [15:0]             beats_written,
    output logic                    load_done,
    output logic                    err_misaligned,
    output logic [31:0]             checksum
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = ADDR_WIDTH - 6;
    localparam int PTR_W  = $clog2(AW_FIFO_DEPTH);

    logic en_q;
    logic en_rise;

    logic [IDX_W-1:0] aw_mem [AW_FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             fifo_full;
    logic             fifo_nonempty;

    logic              w_reg_valid;
    logic [DATA_WIDTH-1:0] w_reg_data;
    logic [STRB_W-1:0] w_reg_strb;

    logic        aw_fire;
    logic        w_fire;
    logic        pair_fire;
    logic [15:0] beats_next;
    logic        load_done_next;

    assign en_rise       = program_load_en && !en_q;
    assign fifo_nonempty = (wr_ptr != rd_ptr);
    assign fifo_full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                           (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // Readies are held low while rst is asserted so no handshake can land during reset.
    assign program_load_aw_ready = program_load_en && !rst && !fifo_full;
    assign pair_fire             = program_load_en && fifo_nonempty && w_reg_valid;
    assign program_load_w_ready  = program_load_en && !rst && (!w_reg_valid || pair_fire);
    assign aw_fire               = program_load_aw_valid && program_load_aw_ready;
    assign w_fire                = program_load_w_valid && program_load_w_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) en_q <= 1'b0;
        else     en_q <= program_load_en;
    end

    // Pointers flush while en is low; nothing can be pushed then, so this equals a falling-edge flush.
    always_ff @(posedge clk) begin
        if (rst || !program_load_en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (aw_fire)   wr_ptr <= wr_ptr + 1'b1;
            if (pair_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the address storage is deliberately not reset; validity comes only from the pointers.
    always_ff @(posedge clk) begin
        if (aw_fire) aw_mem[wr_ptr[PTR_W-1:0]] <= program_load_aw_payload_addr[ADDR_WIDTH-1:6];
    end

    always_ff @(posedge clk) begin
        if (rst || !program_load_en) w_reg_valid <= 1'b0;
        else if (w_fire)             w_reg_valid <= 1'b1;
        else if (pair_fire)          w_reg_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            w_reg_data <= program_load_w_payload_data;
            w_reg_strb <= program_load_w_payload_strb;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        beats_next = beats_written;
        if (en_rise)
            beats_next = '0;
        else if (pair_fire && beats_written != 16'hFFFF)
            beats_next = beats_written + 16'd1;
    end

    assign load_done_next = ({10'd0, beats_next, 6'd0} >= IMAGE_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_written <= '0;
            load_done     <= 1'b0;
        end else begin
            beats_written <= beats_next;
            load_done     <= load_done_next;
        end
    end

    // A misaligned accept in the rising-edge cycle belongs to the new load, so set wins over clear.
    always_ff @(posedge clk) begin
        if (rst)
            err_misaligned <= 1'b0;
        else if (aw_fire && program_load_aw_payload_addr[5:0] != 6'd0)
            err_misaligned <= 1'b1;
        else if (en_rise)
            err_misaligned <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= pair_fire;
            if (pair_fire) begin
                mem_addr  <= aw_mem[rd_ptr[PTR_W-1:0]];
                mem_wdata <= w_reg_data;
                mem_wstrb <= w_reg_strb;
            end
        end
    end

`ifdef PROGRAM_LOAD_CHECKSUM_EN
    logic [31:0] beat_sum;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < DATA_WIDTH / 32; i++)
            if (&w_reg_strb[4*i +: 4]) beat_sum = beat_sum ^ w_reg_data[32*i +: 32];
    end

    // Updated on the pairing edge so the new value appears alongside the write it covers.
    always_ff @(posedge clk) begin
        if (rst || en_rise)  checksum <= '0;
        else if (pair_fire)  checksum <= checksum ^ beat_sum;
    end
`else
    assign checksum = '0;
`endif

endmodule
